// File: rtl/equation_result_buffer_if.sv
// Output handshake between the equation result buffer and its downstream
// consumer (display/UART formatter).
interface equation_result_buffer_if #(
  parameter int unsigned DATA_W = 16
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sel;

  modport master (
    output out_valid,
    output out_data,
    output out_sel,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_sel,
    output out_ready
  );
endinterface

// File: rtl/equation_result_buffer.sv
// Captures the finished equation's result on every equationFlag toggle and
// queues it, tagged with its select, in a small first-word-fall-through FIFO.
module equation_result_buffer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 equationFlag,
  input  logic [DATA_W-1:0]    A,
  input  logic [DATA_W-1:0]    B,
  input  logic                 clear,
  equation_result_buffer_if.master out_if,
  output logic [PTR_W:0]       count,
  output logic                 overflow
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic              flag_q,     flag_d;
  logic              armed_q,    armed_d;
  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]  count_q,    count_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic              sel_q  [DEPTH];
  logic              sel_d  [DEPTH];

  logic toggle;
  logic pop;
  logic full;
  logic push;

  // Handshake and capture decisions for the current cycle
  always_comb begin
    toggle = armed_q && (equationFlag != flag_q);
    pop    = (count_q != '0) && out_if.out_ready;
    full   = (count_q == CNT_W'(DEPTH));
    push   = toggle && (!full || pop);
  end

  // Next-state: flag tracking runs unconditionally; clear overrides the FIFO
  always_comb begin
    flag_d     = equationFlag;
    armed_d    = 1'b1;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    data_d     = data_q;
    sel_d      = sel_q;

    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = flag_q ? B : A;
        sel_d[wr_ptr_q]  = flag_q;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
      if (toggle && full && !pop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q     <= 1'b0;
      armed_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        sel_q[i]  <= 1'b0;
      end
    end else begin
      flag_q     <= flag_d;
      armed_q    <= armed_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
    end
  end

  // Head of queue falls straight through to the consumer
  always_comb begin
    out_if.out_valid = (count_q != '0);
    out_if.out_data  = data_q[rd_ptr_q];
    out_if.out_sel   = sel_q[rd_ptr_q];
    count            = count_q;
    overflow         = overflow_q;
  end

endmodule

// File: doc/equation_result_buffer.md
Name: equation_result_buffer

Overview:
- Downstream consumer of the equation controller.
- The controller alternates between two equations under equationFlag and presents results on A and B (16-bit each).
- This block detects each equationFlag toggle and captures the result of the equation that was just active, tagging each entry with its equation select.
- Captured entries are queued in a small first-word-fall-through FIFO and presented to the next stage (display/UART formatter) over a valid/ready handshake.

Parameters:
- DATA_W, 16, width of A, B and out_data.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- equationFlag  in  1  equation select from the controller (0 = A equation, 1 = B equation).
- A  in  DATA_W  controller result A.
- B  in  DATA_W  controller result B.
- clear  in  1  synchronous flush of FIFO and overflow flag.
- out_ready  in  1  downstream accepts head entry.
- out_valid  out  1  head entry valid.
- out_data  out  DATA_W  head entry result.
- out_sel  out  1  head entry equation tag (0 = from A, 1 = from B).
- count  out  PTR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; at least one capture dropped because the FIFO was full.

Behaviour:
- Reset: when rst_n is low, immediately clear flag_q, armed, pointers, count, overflow and all storage to 0. Consequently out_valid=0, out_data=0, out_sel=0, count=0 and overflow=0. Reset takes effect mid-operation; any queued entries are lost.
- Arming: the first rising clk after rst_n deasserts loads flag_q <= equationFlag and sets armed=1, with no capture. This prevents a spurious push when equationFlag is 1 out of reset.
- Toggle detect: toggle = armed && (equationFlag != flag_q). flag_q <= equationFlag every cycle.
- Capture: on toggle, the push candidate is {sel=flag_q, data = flag_q ? B : A}, sampled in the same cycle.
- Pop: pop = out_valid && out_ready.
- Push acceptance:
  - push = toggle && (count < DEPTH || pop).
  - If toggle && count == DEPTH && !pop, drop the new entry, set overflow=1 and leave the FIFO unchanged.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a toggle sampled at edge N, into an empty FIFO, gives out_valid=1 with that entry on out_data/out_sel after edge N (visible in cycle N+1).
- First-word fall-through: out_valid = (count != 0). out_data/out_sel come straight from the head storage, with no extra register stage. They hold stable while out_valid && !out_ready.
- Empty: pop cannot occur. A simultaneous toggle pushes normally.
- Full with toggle and pop: both occur, count stays at DEPTH, overflow unchanged.
- Pointer wrap: rd/wr pointers are PTR_W bits and wrap modulo DEPTH. Full/empty are distinguished by count, not by pointer compare.
- Clear:
  - Synchronous; takes priority over push and pop in that cycle.
  - Resets pointers, count and overflow to 0.
  - Leaves flag_q and armed running, so a toggle in the clear cycle is discarded.
- Overflow: sticky; cleared only by rst_n or clear.
- Toggle rate: one equationFlag toggle per cycle maximum is supported; every toggle is a capture opportunity.

Test Plan:
- Alternating stream:
  - Stimulus: after reset, equationFlag toggles every cycle; A=16'h0010, B=16'h0020 constant; out_ready=1.
  - Required: out_valid=1 from the cycle after the first toggle; out_sel alternates 0,1,0,...; out_data alternates 0010, 0020; count never exceeds 1; overflow=0.
- Arming:
  - Stimulus: equationFlag held at 1 through reset release, then held for 3 cycles.
  - Required: count=0 and out_valid=0 throughout (no spurious push).
- Fill and overflow:
  - Stimulus: out_ready=0, six toggles with A/B set to distinct values per cycle (0x0001..0x0006 on the selected input).
  - Required: count=4; overflow=1; draining with out_ready=1 returns exactly the first four values in order; count reaches 0.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full, out_ready=1, toggle in the same cycle.
  - Required: count stays 4; overflow stays 0; head advances; new entry appears last on drain.
- Clear vs toggle:
  - Stimulus: count=3, then clear=1 in the same cycle as a toggle.
  - Required: next cycle count=0, out_valid=0, overflow=0; the following toggle pushes normally.
- Reset mid-operation:
  - Stimulus: count=2, overflow=1; pull rst_n low between clock edges.
  - Required: out_valid, count and overflow go to 0 immediately without a clock edge; after release, one arming cycle occurs before captures resume.
